adc_poll_master: RTL and testbench
==================================

// Module: adc_poll_master
// PURPOSE
//  Avalon-MM read master that periodically polls the MAX10 ADC Avalon slave (word 0).
//  Averages 2**AVG_LOG2 consecutive 12-bit samples and queues each mean in a small FIFO.
//  FIFO drains through an Avalon-ST source (valid/ready) to downstream logic.
//  Sits directly downstream of the ADC slave, in the same clk domain.
// PARAMETERS
//  POLL_DIV    100  clk cycles from the end of one transaction to the next read request (>=2)
//  AVG_LOG2    3    log2 of samples per average (0..4); 0 = pass-through
//  FIFO_DEPTH  8    FIFO entries, power of two, >=2
//  TIMEOUT     64   max cycles read may stay asserted without readdatavalid
// PORTS
//  clk            in   1   system clock
//  reset          in   1   async active-low reset
//  enable         in   1   1 = polling runs; 0 = finish current transaction, then idle
//  avm_address    out  1   always 0 (ADC data word)
//  avm_read       out  1   read request
//  avm_burstcount out  1   constant 1
//  avm_readdata   in   16  slave data; bits [11:0] hold the sample
//  avm_readdatavalid in 1  slave data valid
//  src_data       out  16  {4'b0, mean[11:0]}
//  src_valid      out  1   FIFO not empty
//  src_ready      in   1   consumer accepts src_data when src_valid & src_ready
//  overflow       out  1   sticky: a mean was dropped because the FIFO was full
//  timeout        out  1   sticky: a read timed out
//  clr_flags      in   1   sync clear of overflow/timeout; set has priority on the same cycle
// BEHAVIOUR
//  Reset: avm_read=0, avm_address=0, src_valid=0, src_data=0, overflow=0, timeout=0,
//   FIFO empty, accumulator/sample count=0, poll counter=0, state=IDLE.
//  FSM states: IDLE, REQ, DRAIN.
//   IDLE:  poll counter counts to POLL_DIV-1 while enable=1, then -> REQ.
//          enable=0 holds the counter at 0.
//   REQ:   avm_read=1 is held until avm_readdatavalid=1.
//          On that cycle: capture readdata[11:0], drop read on the next edge, -> DRAIN.
//          If TIMEOUT cycles pass with no valid: drop read, set timeout,
//          discard the partial accumulation, -> IDLE.
//   DRAIN: wait for avm_readdatavalid=0, then -> IDLE with poll counter=0.
//  Accumulator is 12+AVG_LOG2 bits, unsigned, and cannot overflow.
//   When sample count reaches 2**AVG_LOG2: mean = acc >> AVG_LOG2 (truncated);
//   push the mean, then clear acc and count.
//  Push happens one cycle after the final sample is captured.
//  FIFO full on push: the mean is dropped and overflow is set.
//   Pop on the same cycle frees a slot, so the push is accepted.
//  Push into an empty FIFO: src_valid rises the next cycle (1-cycle latency).
//   src_data is stable while src_valid=1 and src_ready=0.
//  Pointers wrap modulo FIFO_DEPTH. Full/empty come from an extra pointer MSB.
//  enable falling mid-REQ: the transaction completes normally.
//   The accumulator is kept, and the window resumes when enable returns.
//  Async reset mid-transaction: read drops immediately and FIFO contents are lost.
// CONFIGURATION
//  `ADC_POLL_MINMAX_EN defined: extra outputs win_min[11:0] and win_max[11:0].
//   They latch the min/max of each window on the cycle its mean is pushed.
//   Reset values: win_min=12'hFFF, win_max=0.
//  Not defined: these ports and their logic are absent. All other behaviour is identical.
// STRUCTURE
//  adc_poll_pkg: state enum t_poll_st {IDLE,REQ,DRAIN}, localparam ADC_W=12, ADC_ADDR_DATA=1'b0.
//  Sub-module adc_sample_fifo: synchronous FIFO with params W, DEPTH; ports push, pop, din,
//   dout, full, empty. First-word-fall-through.
// TESTING
//  1. AVG_LOG2=0, POLL_DIV=10; slave returns 12'h123 -> src_data=16'h0123 and
//     read pulses ~every 10+latency cycles.
//  2. AVG_LOG2=2; samples 100,101,102,103 -> one push of mean 101 (406>>2).
//     No push after 3 samples.
//  3. src_ready=0, FIFO_DEPTH=8, AVG_LOG2=0 -> 8 entries held; the 9th sets overflow.
//     Then clr_flags -> overflow=0; pop order = FIFO order.
//  4. Slave never asserts readdatavalid, TIMEOUT=64 -> read drops after 64 cycles,
//     timeout=1, the next read follows POLL_DIV later.
//  5. Full FIFO with src_ready=1 on the push cycle -> push accepted, overflow stays 0.
//  6. reset low during REQ -> avm_read=0 asynchronously; all outputs at reset values.
//     With `ADC_POLL_MINMAX_EN, samples 5,9,2,7 (AVG_LOG2=2) -> win_min=2, win_max=9.

Source files
------------

// File: rtl/adc_poll_pkg.sv
// ---------------------------------------------------------------------------
// adc_poll_pkg
// Shared definitions for the ADC polling master. It holds the FSM state type,
// the ADC sample width and the Avalon word address of the ADC data register.
// The package has no ports.
// ---------------------------------------------------------------------------
package adc_poll_pkg;

  localparam int   ADC_W         = 12;
  localparam logic ADC_ADDR_DATA = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } t_poll_st;

endpackage : adc_poll_pkg

// File: rtl/adc_sample_fifo.sv
// ---------------------------------------------------------------------------
// adc_sample_fifo
// Synchronous first-word-fall-through FIFO. Each pointer carries one extra MSB,
// so full and empty can be told apart when the low pointer bits are equal.
// A push into a full FIFO is accepted only when a pop happens on the same cycle.
// Ports:
//   clk, reset      clock and asynchronous active-low reset
//   push, din       write request and write data
//   pop             read request; it is ignored while the FIFO is empty
//   dout            head entry, valid whenever empty = 0
//   full, empty     occupancy status
// ---------------------------------------------------------------------------
module adc_sample_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         wr_en_s;
  logic         rd_en_s;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en_s = pop & ~empty;
  // A simultaneous pop frees the slot that a push into a full FIFO needs.
  assign wr_en_s = push & (~full | rd_en_s);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer and storage registers; reset clears the contents
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (wr_en_s) begin
        mem_q[wr_ptr_q[AW-1:0]] <= din;
      end
    end
  end

endmodule : adc_sample_fifo

// File: rtl/adc_poll_master.sv
// ---------------------------------------------------------------------------
// adc_poll_master
// Avalon-MM read master that polls word 0 of the MAX10 ADC slave. It averages
// 2**AVG_LOG2 consecutive 12-bit samples and queues each mean in a FIFO. The
// FIFO drains through an Avalon-ST source.
// Ports:
//   clk, reset                 clock and asynchronous active-low reset
//   enable                     polling runs while 1; a transaction in flight
//                              always completes
//   avm_address/read/burstcount/readdata/readdatavalid
//                              Avalon-MM master port (address 0, burst 1)
//   src_data/src_valid/src_ready
//                              Avalon-ST source, {4'b0, mean}
//   overflow, timeout          sticky flags; set has priority over clr_flags
//   clr_flags                  synchronous clear of both flags
// Optional feature: when ADC_POLL_MINMAX_EN is defined, the outputs win_min and
// win_max report the min/max sample of the most recently pushed window.
// ---------------------------------------------------------------------------
module adc_poll_master
  import adc_poll_pkg::*;
#(
  parameter int POLL_DIV   = 100,
  parameter int AVG_LOG2   = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        avm_address,
  output logic        avm_read,
  output logic        avm_burstcount,
  input  logic [15:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic [15:0] src_data,
  output logic        src_valid,
  input  logic        src_ready,
  output logic        overflow,
  output logic        timeout,
  input  logic        clr_flags
`ifdef ADC_POLL_MINMAX_EN
  ,
  output logic [ADC_W-1:0] win_min,
  output logic [ADC_W-1:0] win_max
`endif
);

  localparam int PW    = $clog2(POLL_DIV + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;

  localparam logic [PW-1:0]    POLL_LAST = PW'(POLL_DIV - 1);
  localparam logic [TW-1:0]    TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WIN_N     = CNT_W'(1 << AVG_LOG2);

  t_poll_st         state_q, state_d;
  logic [PW-1:0]    poll_q, poll_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             read_q, read_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overflow_q, overflow_d;
  logic             timeout_q, timeout_d;

  logic [ADC_W-1:0] sample_s;
  logic [ADC_W-1:0] mean_s;
  logic [ADC_W-1:0] dout_s;
  logic             cap_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic             tmo_set_s;
  logic             ovf_set_s;
  logic             unused_s;

  assign sample_s  = avm_readdata[ADC_W-1:0];
  assign unused_s  = ^avm_readdata[15:ADC_W];
  assign cap_s     = (state_q == REQ) & avm_readdatavalid;
  // The window closes on the cycle after its last capture, so the push
  // never coincides with a capture or a timeout.
  assign push_s    = (cnt_q == WIN_N);
  assign mean_s    = ADC_W'(acc_q >> AVG_LOG2);
  assign pop_s     = ~empty_s & src_ready;
  assign ovf_set_s = push_s & full_s & ~pop_s;

  assign avm_address    = ADC_ADDR_DATA;
  assign avm_burstcount = 1'b1;
  assign avm_read       = read_q;
  assign src_valid      = ~empty_s;
  assign src_data       = {{(16-ADC_W){1'b0}}, dout_s};
  assign overflow       = overflow_q;
  assign timeout        = timeout_q;

  adc_sample_fifo #(
    .W     (ADC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (mean_s),
    .dout  (dout_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Poll FSM next state, counters and averaging accumulator
  always_comb begin
    state_d   = state_q;
    poll_d    = poll_q;
    tmo_d     = tmo_q;
    read_d    = read_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    tmo_set_s = 1'b0;
    if (push_s) begin
      acc_d = '0;
      cnt_d = '0;
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
    case (state_q)
      IDLE: begin
        read_d = 1'b0;
        tmo_d  = '0;
        if (enable) begin
          if (poll_q == POLL_LAST) begin
            poll_d  = '0;
            read_d  = 1'b1;
            state_d = REQ;
          end else begin
            poll_d = poll_q + PW'(1);
          end
        end else begin
          poll_d = '0;
        end
      end
      REQ: begin
        if (cap_s) begin
          acc_d   = acc_q + ACC_W'(sample_s);
          cnt_d   = cnt_q + CNT_W'(1);
          read_d  = 1'b0;
          tmo_d   = '0;
          state_d = DRAIN;
        end else if (tmo_q == TMO_LAST) begin
          // The slave never answered: abandon the window in progress.
          acc_d     = '0;
          cnt_d     = '0;
          read_d    = 1'b0;
          tmo_d     = '0;
          poll_d    = '0;
          tmo_set_s = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      DRAIN: begin
        if (!avm_readdatavalid) begin
          poll_d  = '0;
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        read_d  = 1'b0;
        poll_d  = '0;
        tmo_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Sticky flags: a set on the same cycle wins over clr_flags
  always_comb begin
    overflow_d = ovf_set_s | (overflow_q & ~clr_flags);
    timeout_d  = tmo_set_s | (timeout_q & ~clr_flags);
  end

  // FSM state, counters, read strobe, accumulator and flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      poll_q     <= '0;
      tmo_q      <= '0;
      read_q     <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      poll_q     <= poll_d;
      tmo_q      <= tmo_d;
      read_q     <= read_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef ADC_POLL_MINMAX_EN
  logic [ADC_W-1:0] run_min_q, run_min_d;
  logic [ADC_W-1:0] run_max_q, run_max_d;
  logic [ADC_W-1:0] win_min_q, win_min_d;
  logic [ADC_W-1:0] win_max_q, win_max_d;

  assign win_min = win_min_q;
  assign win_max = win_max_q;

  // Running window extremes, published when the window mean is pushed
  always_comb begin
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    win_min_d = win_min_q;
    win_max_d = win_max_q;
    if (push_s) begin
      win_min_d = run_min_q;
      win_max_d = run_max_q;
      run_min_d = '1;
      run_max_d = '0;
    end else if (cap_s) begin
      if (sample_s < run_min_q) begin
        run_min_d = sample_s;
      end else begin
        run_min_d = run_min_q;
      end
      if (sample_s > run_max_q) begin
        run_max_d = sample_s;
      end else begin
        run_max_d = run_max_q;
      end
    end else if (tmo_set_s) begin
      run_min_d = '1;
      run_max_d = '0;
    end else begin
      run_min_d = run_min_q;
      run_max_d = run_max_q;
    end
  end

  // Min/max registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_min_q <= '1;
      run_max_q <= '0;
      win_min_q <= 12'hFFF;
      win_max_q <= 12'h000;
    end else begin
      run_min_q <= run_min_d;
      run_max_q <= run_max_d;
      win_min_q <= win_min_d;
      win_max_q <= win_max_d;
    end
  end
`endif

endmodule : adc_poll_master

// File: tb/tb_adc_poll_master.sv
// ---------------------------------------------------------------------------
// tb_adc_poll_master
// Directed bench with two instances sharing clk and reset. u0 runs with
// AVG_LOG2=0 (pass-through) and u2 runs with AVG_LOG2=2. Both use POLL_DIV=10,
// FIFO_DEPTH=8 and TIMEOUT=64. While one instance is under test, the other
// instance is held idle with enable=0.
// ---------------------------------------------------------------------------
module tb_adc_poll_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        en0, en2, rdv0, rdv2, rdy0, rdy2, clr0, clr2;
  logic [15:0] rdata0, rdata2;
  logic        addr0, read0, bc0, valid0, ovf0, tmo0;
  logic        addr2, read2, bc2, valid2, ovf2, tmo2;
  logic [15:0] data0, data2;
`ifdef ADC_POLL_MINMAX_EN
  logic [11:0] wmin0, wmax0, wmin2, wmax2;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n;

  always #5 clk = ~clk;

  adc_poll_master #(.POLL_DIV(10), .AVG_LOG2(0), .FIFO_DEPTH(8), .TIMEOUT(64)) u0 (
    .clk(clk), .reset(reset), .enable(en0),
    .avm_address(addr0), .avm_read(read0), .avm_burstcount(bc0),
    .avm_readdata(rdata0), .avm_readdatavalid(rdv0),
    .src_data(data0), .src_valid(valid0), .src_ready(rdy0),
    .overflow(ovf0), .timeout(tmo0), .clr_flags(clr0)
`ifdef ADC_POLL_MINMAX_EN
    , .win_min(wmin0), .win_max(wmax0)
`endif
  );

  adc_poll_master #(.POLL_DIV(10), .AVG_LOG2(2), .FIFO_DEPTH(8), .TIMEOUT(64)) u2 (
    .clk(clk), .reset(reset), .enable(en2),
    .avm_address(addr2), .avm_read(read2), .avm_burstcount(bc2),
    .avm_readdata(rdata2), .avm_readdatavalid(rdv2),
    .src_data(data2), .src_valid(valid2), .src_ready(rdy2),
    .overflow(ovf2), .timeout(tmo2), .clr_flags(clr2)
`ifdef ADC_POLL_MINMAX_EN
    , .win_min(wmin2), .win_max(wmax2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rd(input int w);
    return (w == 2) ? read2 : read0;
  endfunction

  // Count falling edges until the selected read is high; the wait is bounded.
  task automatic wait_read(input int w, input int limit, output int cnt);
    cnt = 0;
    while (!rd(w) && cnt < limit) begin
      @(negedge clk);
      cnt++;
    end
    if (!rd(w)) begin
      n_checks++;
      n_fail++;
      $error("FAIL wait_read%0d: read still 0 after %0d cycles, expected 1", w, limit);
    end
  endtask

  // Slave response: after lat cycles, present data with readdatavalid for one cycle.
  task automatic serve(input int w, input logic [15:0] d, input int lat);
    int c;
    wait_read(w, 300, c);
    repeat (lat) @(negedge clk);
    if (w == 2) begin rdata2 = d; rdv2 = 1'b1; end
    else        begin rdata0 = d; rdv0 = 1'b1; end
    @(negedge clk);
    if (w == 2) begin rdv2 = 1'b0; end
    else        begin rdv0 = 1'b0; end
  endtask

  task automatic pop(input int w);
    if (w == 2) rdy2 = 1'b1; else rdy0 = 1'b1;
    @(negedge clk);
    if (w == 2) rdy2 = 1'b0; else rdy0 = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    en0 = 1'b0; en2 = 1'b0; rdv0 = 1'b0; rdv2 = 1'b0;
    rdy0 = 1'b0; rdy2 = 1'b0; clr0 = 1'b0; clr2 = 1'b0;
    rdata0 = 16'h0000; rdata2 = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_read0", read0, 1'b0);
    check("rst_read2", read2, 1'b0);
    check("rst_valid0", valid0, 1'b0);
    check("rst_data0", data0, 16'h0000);
    check("rst_ovf0", ovf0, 1'b0);
    check("rst_tmo0", tmo0, 1'b0);
    check("addr0", addr0, 1'b0);
    check("burst0", bc0, 1'b1);
`ifdef ADC_POLL_MINMAX_EN
    check("rst_wmin2", wmin2, 12'hFFF);
    check("rst_wmax2", wmax2, 12'h000);
`endif

    // 1: pass-through, upper readdata bits masked, poll spacing
    en0 = 1'b1;
    serve(0, 16'hF123, 2);
    @(negedge clk);
    check("t1_valid", valid0, 1'b1);
    check("t1_data", data0, 16'h0123);
    // One falling edge has already passed since capture; POLL_DIV+1 edges in total.
    wait_read(0, 50, n);
    check("t1_gap", n, 10);
    serve(0, 16'h0456, 0);
    en0 = 1'b0;
    @(negedge clk);
    check("t1_hold", data0, 16'h0123);
    pop(0);
    check("t1_second", data0, 16'h0456);
    pop(0);
    check("t1_empty", valid0, 1'b0);

    // 3: fill to depth with no consumer, ninth mean overflows, clear, drain in order
    en0 = 1'b1;
    for (int i = 0; i < 8; i++) serve(0, 16'h0200 + 16'(i), 1);
    @(negedge clk);
    check("t3_ovf_at8", ovf0, 1'b0);
    check("t3_head", data0, 16'h0200);
    serve(0, 16'h02FF, 0);
    en0 = 1'b0;
    @(negedge clk);
    check("t3_ovf_at9", ovf0, 1'b1);
    check("t3_head_kept", data0, 16'h0200);
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    check("t3_ovf_clr", ovf0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("t3_order", data0, 16'h0200 + 16'(i));
      pop(0);
    end
    check("t3_empty", valid0, 1'b0);

    // 5: full FIFO with a pop on the push cycle accepts the push
    en0 = 1'b1;
    for (int i = 0; i < 8; i++) serve(0, 16'h0300 + 16'(i), 1);
    serve(0, 16'h03AA, 1);
    rdy0 = 1'b1;
    en0  = 1'b0;
    @(negedge clk);
    rdy0 = 1'b0;
    check("t5_ovf", ovf0, 1'b0);
    for (int i = 1; i < 9; i++) begin
      check("t5_order", data0, (i == 8) ? 16'h03AA : 16'h0300 + 16'(i));
      pop(0);
    end
    check("t5_empty", valid0, 1'b0);

    // 4: slave silent: read held TIMEOUT cycles, flag set, next read POLL_DIV later
    en0 = 1'b1;
    wait_read(0, 50, n);
    n = 0;
    while (read0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t4_read_len", n, 64);
    check("t4_tmo", tmo0, 1'b1);
    wait_read(0, 50, n);
    check("t4_gap", n, 10);
    serve(0, 16'h0055, 0);
    en0 = 1'b0;
    @(negedge clk);
    check("t4_data", data0, 16'h0055);
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    check("t4_tmo_clr", tmo0, 1'b0);
    pop(0);

    // 2: averaging of four samples, no push after three
    en2 = 1'b1;
    serve(2, 16'd100, 1);
    serve(2, 16'd101, 1);
    serve(2, 16'd102, 1);
    repeat (3) @(negedge clk);
    check("t2_no_push3", valid2, 1'b0);
    serve(2, 16'd103, 1);
    @(negedge clk);
    check("t2_valid", valid2, 1'b1);
    check("t2_mean", data2, 16'd101);
    pop(2);
    // Truncation (7>>2=1) and the full-scale window (4*4095>>2=4095)
    serve(2, 16'd1, 0);
    serve(2, 16'd2, 0);
    serve(2, 16'd2, 0);
    serve(2, 16'd2, 0);
    for (int i = 0; i < 4; i++) serve(2, 16'h0FFF, 0);
    @(negedge clk);
    check("t2_trunc", data2, 16'd1);
    pop(2);
    check("t2_full", data2, 16'h0FFF);
    pop(2);
    check("t2_empty", valid2, 1'b0);

    // enable falling mid-REQ: transaction completes and the window is kept
    serve(2, 16'd10, 1);
    wait_read(2, 50, n);
    en2 = 1'b0;
    serve(2, 16'd20, 3);
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (read2) n++;
    end
    check("en_idle_reads", n, 0);
    check("en_no_push", valid2, 1'b0);
    en2 = 1'b1;
    serve(2, 16'd30, 1);
    serve(2, 16'd40, 1);
    en2 = 1'b0;
    @(negedge clk);
    check("en_valid", valid2, 1'b1);
    check("en_mean", data2, 16'd25);
    pop(2);

    // Window 5,9,2,7: mean 23>>2=5; min/max when enabled
    en2 = 1'b1;
    serve(2, 16'd5, 0);
    serve(2, 16'd9, 0);
    serve(2, 16'd2, 0);
    serve(2, 16'd7, 0);
    @(negedge clk);
    check("mm_mean", data2, 16'd5);
`ifdef ADC_POLL_MINMAX_EN
    check("mm_min", wmin2, 12'd2);
    check("mm_max", wmax2, 12'd9);
`endif

    // 6: asynchronous reset in the middle of REQ
    wait_read(2, 50, n);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("t6_read", read2, 1'b0);
    check("t6_valid", valid2, 1'b0);
    check("t6_data", data2, 16'h0000);
    check("t6_ovf", ovf2, 1'b0);
    check("t6_tmo", tmo2, 1'b0);
`ifdef ADC_POLL_MINMAX_EN
    check("t6_wmin", wmin2, 12'hFFF);
    check("t6_wmax", wmax2, 12'h000);
`endif
    en2 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_adc_poll_master
